// File: rtl/data_frame_pkg.sv
// Shared definitions for the three-word frame link (transmitter and receiver).
package data_frame_pkg;

  typedef enum logic [1:0] {
    W0      = 2'd0,
    W1      = 2'd1,
    W2      = 2'd2,
    DISCARD = 2'd3
  } rx_state_e;

  localparam int FRAME_WORDS = 3;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_KEEP_W  = DEF_DATA_W / 8;
  localparam int DEF_CNT_W   = 16;

  localparam logic [DEF_KEEP_W-1:0] KEEP_ALL = {DEF_KEEP_W{1'b1}};

endpackage

// File: rtl/data_frame_rx_if.sv
// Aurora RX user stream: master drives beats, slave consumes every valid beat.
interface data_frame_rx_if #(
  parameter int DATA_W = data_frame_pkg::DEF_DATA_W,
  parameter int KEEP_W = DATA_W / 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_last;
  logic [KEEP_W-1:0] rx_keep;

  modport master (output rx_data, output rx_valid, output rx_last, output rx_keep);
  modport slave  (input  rx_data, input  rx_valid, input  rx_last, input  rx_keep);
endinterface

// File: rtl/data_frame_rx_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = data_frame_pkg::DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/data_frame_rx.sv
// Reassembles 3-beat Aurora RX frames into data_1..3; flags and counts malformed frames.
module data_frame_rx
  import data_frame_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int KEEP_W = DATA_W / 8,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  data_frame_rx_if.slave    rx,
  output logic [DATA_W-1:0] data_1,
  output logic [DATA_W-1:0] data_2,
  output logic [DATA_W-1:0] data_3,
  output logic              frame_valid,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  rx_state_e         state_q;
  logic [DATA_W-1:0] shadow_q [FRAME_WORDS-1];
  logic [DATA_W-1:0] data_1_q, data_2_q, data_3_q;
  logic              frame_valid_q, frame_err_q;
  logic              good_d, bad_d;

  // Terminating-beat classification, shared by the FSM and the counters.
  always_comb begin
    good_d = 1'b0;
    bad_d  = 1'b0;
    if (rx.rx_valid && rx.rx_last) begin
      if (state_q == W2 && (&rx.rx_keep)) begin
        good_d = 1'b1;
      end else begin
        bad_d = 1'b1;
      end
    end
  end

  // NOTE: the shadow words are only two registers, so they are reset with the rest of the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= W0;
      shadow_q[0]   <= '0;
      shadow_q[1]   <= '0;
      data_1_q      <= '0;
      data_2_q      <= '0;
      data_3_q      <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      frame_valid_q <= good_d;
      frame_err_q   <= bad_d;
      if (rx.rx_valid) begin
        case (state_q)
          W0: begin
            if (!rx.rx_last) begin
              shadow_q[0] <= rx.rx_data;
              state_q     <= W1;
            end
          end
          W1: begin
            if (rx.rx_last) begin
              state_q <= W0;
            end else begin
              shadow_q[1] <= rx.rx_data;
              state_q     <= W2;
            end
          end
          W2: begin
            if (rx.rx_last) begin
              state_q <= W0;
              if (good_d) begin
                data_1_q <= shadow_q[0];
                data_2_q <= shadow_q[1];
                data_3_q <= rx.rx_data;
              end
            end else begin
              state_q <= DISCARD;
            end
          end
          DISCARD: begin
            if (rx.rx_last) begin
              state_q <= W0;
            end
          end
          default: state_q <= W0;
        endcase
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (good_d),
    .count (frame_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bad_d),
    .count (err_cnt)
  );

  assign data_1      = data_1_q;
  assign data_2      = data_2_q;
  assign data_3      = data_3_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_data_frame_rx.sv
// Directed self-checking bench for data_frame_rx and its saturating counter.
module tb_data_frame_rx;
  import data_frame_pkg::*;

  localparam int DATA_W = 32;
  localparam int KEEP_W = 4;
  localparam int CNT_W  = 16;

  logic clk;
  logic reset;
  logic [DATA_W-1:0] data_1, data_2, data_3;
  logic frame_valid, frame_err;
  logic [CNT_W-1:0] frame_cnt, err_cnt;

  logic       sat_inc;
  logic [1:0] sat_count;

  int tests;
  int fails;
  int vcnt, ecnt, both_cnt;

  data_frame_rx_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) rx_if ();

  data_frame_rx #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx_if.slave),
    .data_1      (data_1),
    .data_2      (data_2),
    .data_3      (data_3),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt)
  );

  sat_counter #(.CNT_W(2)) u_sat (
    .clk   (clk),
    .reset (reset),
    .inc   (sat_inc),
    .count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) vcnt++;
    if (frame_err) ecnt++;
    if (frame_valid && frame_err) both_cnt++;
  end

  // Drive one beat; returns #1 after the edge that samples it.
  task automatic send_beat(input logic [DATA_W-1:0] d, input logic last, input logic [KEEP_W-1:0] keep);
    rx_if.rx_data  = d;
    rx_if.rx_last  = last;
    rx_if.rx_keep  = keep;
    rx_if.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_data(input string name, input logic [DATA_W-1:0] e1, e2, e3);
    tests++;
    if (data_1 !== e1 || data_2 !== e2 || data_3 !== e3) begin
      fails++;
      $display("FAIL %s: data got %h/%h/%h expected %h/%h/%h", name, data_1, data_2, data_3, e1, e2, e3);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_last  = 1'b0;
    rx_if.rx_data  = '0;
    rx_if.rx_keep  = '0;
    sat_inc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_data("reset_data", '0, '0, '0);
    tests++;
    if (frame_valid !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_strobes: got fv=%b fe=%b expected 0/0", frame_valid, frame_err);
    end
    tests++;
    if (frame_cnt !== '0 || err_cnt !== '0) begin
      fails++;
      $display("FAIL reset_counts: got %0d/%0d expected 0/0", frame_cnt, err_cnt);
    end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_good_frame;
    send_beat(32'hdeadbeef, 1'b0, 4'h0);
    send_beat(32'hcafebabe, 1'b0, 4'h0);
    send_beat(32'h19900614, 1'b1, KEEP_ALL);
    tests++;
    if (frame_valid !== 1'b1 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL good_strobe: got fv=%b fe=%b expected 1/0", frame_valid, frame_err);
    end
    check_data("good_data", 32'hdeadbeef, 32'hcafebabe, 32'h19900614);
    tests++;
    if (frame_cnt !== 16'd1) begin
      fails++;
      $display("FAIL good_cnt: got %0d expected 1", frame_cnt);
    end
    idle(1);
    tests++;
    if (frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL good_pulse_width: got fv=%b expected 0", frame_valid);
    end
  endtask

  task automatic test_gaps;
    int v0, e0;
    v0 = vcnt; e0 = ecnt;
    send_beat(32'h12345678, 1'b0, 4'h0);
    idle(2);
    send_beat(32'h98765432, 1'b0, 4'h0);
    idle(2);
    send_beat(32'habcdef01, 1'b1, KEEP_ALL);
    check_data("gaps_data", 32'h12345678, 32'h98765432, 32'habcdef01);
    idle(2);
    tests++;
    if (vcnt - v0 !== 1 || ecnt - e0 !== 0) begin
      fails++;
      $display("FAIL gaps_pulses: got valid=%0d err=%0d expected 1/0", vcnt - v0, ecnt - e0);
    end
    tests++;
    if (frame_cnt !== 16'd2) begin
      fails++;
      $display("FAIL gaps_cnt: got %0d expected 2", frame_cnt);
    end
  endtask

  task automatic test_short;
    int v0, e0;
    v0 = vcnt; e0 = ecnt;
    send_beat(32'h11111111, 1'b0, 4'h0);
    send_beat(32'h22222222, 1'b1, KEEP_ALL);
    tests++;
    if (frame_err !== 1'b1 || err_cnt !== 16'd1) begin
      fails++;
      $display("FAIL short2_err: got fe=%b err_cnt=%0d expected 1/1", frame_err, err_cnt);
    end
    check_data("short2_hold", 32'h12345678, 32'h98765432, 32'habcdef01);
    send_beat(32'ha0000001, 1'b0, 4'h0);
    send_beat(32'ha0000002, 1'b0, 4'h0);
    send_beat(32'ha0000003, 1'b1, KEEP_ALL);
    tests++;
    if (frame_valid !== 1'b1 || frame_cnt !== 16'd3) begin
      fails++;
      $display("FAIL short_next_good: got fv=%b frame_cnt=%0d expected 1/3", frame_valid, frame_cnt);
    end
    check_data("short_next_data", 32'ha0000001, 32'ha0000002, 32'ha0000003);
    send_beat(32'h33333333, 1'b1, KEEP_ALL);
    tests++;
    if (frame_err !== 1'b1 || err_cnt !== 16'd2) begin
      fails++;
      $display("FAIL short1_err: got fe=%b err_cnt=%0d expected 1/2", frame_err, err_cnt);
    end
    idle(2);
    tests++;
    if (vcnt - v0 !== 1 || ecnt - e0 !== 2) begin
      fails++;
      $display("FAIL short_pulses: got valid=%0d err=%0d expected 1/2", vcnt - v0, ecnt - e0);
    end
  endtask

  task automatic test_long;
    int v0, e0;
    v0 = vcnt; e0 = ecnt;
    for (int i = 1; i <= 4; i++) send_beat(32'hb0000000 + i, 1'b0, 4'h0);
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL long_early_flag: got fe=%b expected 0", frame_err);
    end
    send_beat(32'hb0000005, 1'b1, KEEP_ALL);
    tests++;
    if (frame_err !== 1'b1 || err_cnt !== 16'd3 || frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL long_err: got fe=%b fv=%b err_cnt=%0d expected 1/0/3", frame_err, frame_valid, err_cnt);
    end
    check_data("long_hold", 32'ha0000001, 32'ha0000002, 32'ha0000003);
    send_beat(32'hc0000001, 1'b0, 4'h0);
    send_beat(32'hc0000002, 1'b0, 4'h0);
    send_beat(32'hc0000003, 1'b1, KEEP_ALL);
    check_data("long_next_data", 32'hc0000001, 32'hc0000002, 32'hc0000003);
    idle(1);
    tests++;
    if (vcnt - v0 !== 1 || ecnt - e0 !== 1 || frame_cnt !== 16'd4) begin
      fails++;
      $display("FAIL long_pulses: got valid=%0d err=%0d frame_cnt=%0d expected 1/1/4", vcnt - v0, ecnt - e0, frame_cnt);
    end
  endtask

  task automatic test_keep;
    send_beat(32'hd0000001, 1'b0, 4'h0);
    send_beat(32'hd0000002, 1'b0, 4'h0);
    send_beat(32'hd0000003, 1'b1, 4'h7);
    tests++;
    if (frame_err !== 1'b1 || frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL keep_strobe: got fe=%b fv=%b expected 1/0", frame_err, frame_valid);
    end
    tests++;
    if (frame_cnt !== 16'd4 || err_cnt !== 16'd4) begin
      fails++;
      $display("FAIL keep_counts: got %0d/%0d expected 4/4", frame_cnt, err_cnt);
    end
    check_data("keep_hold", 32'hc0000001, 32'hc0000002, 32'hc0000003);
    idle(1);
  endtask

  task automatic test_reset_midframe;
    int e0;
    send_beat(32'he0000001, 1'b0, 4'h0);
    send_beat(32'he0000002, 1'b0, 4'h0);
    e0 = ecnt;
    reset = 1'b1;
    #1;
    check_data("midreset_data", '0, '0, '0);
    tests++;
    if (frame_cnt !== '0 || err_cnt !== '0 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL midreset_state: got cnt=%0d/%0d fv=%b fe=%b expected 0/0/0/0", frame_cnt, err_cnt, frame_valid, frame_err);
    end
    idle(2);
    reset = 1'b0;
    idle(1);
    send_beat(32'hf0000001, 1'b0, 4'h0);
    send_beat(32'hf0000002, 1'b0, 4'h0);
    send_beat(32'hf0000003, 1'b1, KEEP_ALL);
    tests++;
    if (frame_valid !== 1'b1 || frame_cnt !== 16'd1 || err_cnt !== 16'd0) begin
      fails++;
      $display("FAIL midreset_next: got fv=%b cnt=%0d/%0d expected 1/1/0", frame_valid, frame_cnt, err_cnt);
    end
    check_data("midreset_next_data", 32'hf0000001, 32'hf0000002, 32'hf0000003);
    idle(1);
    tests++;
    if (ecnt !== e0) begin
      fails++;
      $display("FAIL midreset_no_err: got %0d err pulses expected 0", ecnt - e0);
    end
  endtask

  task automatic test_saturation;
    sat_inc = 1'b1;
    idle(2);
    tests++;
    if (sat_count !== 2'd2) begin
      fails++;
      $display("FAIL sat_count2: got %0d expected 2", sat_count);
    end
    idle(3);
    sat_inc = 1'b0;
    tests++;
    if (sat_count !== 2'd3) begin
      fails++;
      $display("FAIL sat_hold: got %0d expected 3", sat_count);
    end
  endtask

  task automatic test_exclusive;
    tests++;
    if (both_cnt !== 0) begin
      fails++;
      $display("FAIL strobe_overlap: got %0d overlapping cycles expected 0", both_cnt);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    vcnt = 0; ecnt = 0; both_cnt = 0;
    test_reset();
    test_good_frame();
    test_gaps();
    test_short();
    test_long();
    test_keep();
    test_reset_midframe();
    test_saturation();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", tests, fails);
    $finish;
  end

endmodule
